// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//
// Shares one single-ported, synchronous-read 32-bit word SRAM between the
// core instruction-fetch port (I) and the core data port (D). At most one
// request is granted per cycle. The grant is combinational in the request
// cycle, and the response (val, rdata, pc/tag, error) appears exactly one
// cycle later. Conflicts are resolved round-robin on rr_last.
//
// Optional feature (macro MEM_PORT_ARB_RANGE_CHECK_EN):
//   defined   - a request with addr[31:AW+2] != 0 is granted without touching
//               the SRAM and is answered with *_error=1 and rdata=0.
//   undefined - upper address bits are ignored (aliasing) and *_error is 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   core__i_*             fetch request (addr, ren)
//   i__core_*             fetch accept and response (val, error, rdata, pc)
//   core__d_*             data request (addr, wdata, ren, wen, req_tag)
//   d__core_*             data accept and response (val, error, rdata, resp_tag)
//   mem_*                 SRAM drive (en, wen, addr, wdata) and read data
// ---------------------------------------------------------------------------
module mem_port_arb #(
   parameter int DEPTH = 16384
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic [31:0]              core__i_addr,
   input  logic                     core__i_ren,
   output logic                     i__core_accept,
   output logic                     i__core_val,
   output logic                     i__core_error,
   output logic [31:0]              i__core_rdata,
   output logic [31:0]              i__core_pc,

   input  logic [31:0]              core__d_addr,
   input  logic [31:0]              core__d_wdata,
   input  logic                     core__d_ren,
   input  logic [3:0]               core__d_wen,
   input  logic [10:0]              core__d_req_tag,
   output logic                     d__core_accept,
   output logic                     d__core_val,
   output logic                     d__core_error,
   output logic [31:0]              d__core_rdata,
   output logic [10:0]              d__core_resp_tag,

   output logic                     mem_en,
   output logic [3:0]               mem_wen,
   output logic [$clog2(DEPTH)-1:0] mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   // Request decode and grant
   logic        req_i;
   logic        req_d;
   logic        grant_i;
   logic        grant_d;
   logic        is_store;
   logic [31:0] sel_addr;
   logic        range_err;

   // Registered state
   port_e       rr_last_q,  rr_last_d;
   logic        i_val_q,    i_val_d;
   logic        d_val_q,    d_val_d;
   logic        err_q,      err_d;
   logic        store_q,    store_d;
   logic [10:0] tag_q,      tag_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] i_rdata_q,  i_rdata_d;
   logic [31:0] d_rdata_q,  d_rdata_d;

   // Response data as seen in a val cycle
   logic [31:0] i_resp_data;
   logic [31:0] d_resp_data;

   // Address bits that never reach the SRAM are folded here on purpose.
   logic        addr_unused;
   assign addr_unused = ^{core__i_addr, core__d_addr};

   always_comb begin
      req_i    = core__i_ren;
      req_d    = core__d_ren | (|core__d_wen);
      is_store = |core__d_wen;

      // D wins unless I is also requesting and D was the last port served.
      // Nothing is granted while reset is asserted.
      grant_d  = ~rst & req_d & (~req_i | (rr_last_q == PORT_I));
      grant_i  = ~rst & req_i & ~grant_d;

      sel_addr = grant_d ? core__d_addr : core__i_addr;

`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
      range_err = (grant_i | grant_d) & (|sel_addr[31:AW+2]);
`else
      range_err = 1'b0;
`endif

      // Out-of-range requests are still accepted but never reach the SRAM.
      mem_en    = (grant_i | grant_d) & ~range_err;
      mem_wen   = {4{grant_d & is_store & ~range_err}} & core__d_wen;
      mem_addr  = sel_addr[AW+1:2];
      mem_wdata = core__d_wdata;
   end

   always_comb begin
      rr_last_d = rr_last_q;
      if (grant_d) begin
         rr_last_d = PORT_D;
      end else if (grant_i) begin
         rr_last_d = PORT_I;
      end

      i_val_d = grant_i;
      d_val_d = grant_d;
      err_d   = range_err;
      store_d = grant_d & is_store;
      tag_d   = grant_d ? core__d_req_tag : tag_q;
      pc_d    = grant_i ? core__i_addr : pc_q;

      // SRAM data is only meaningful for a real read; errored accesses and
      // stores return zero.
      i_resp_data = err_q ? 32'd0 : mem_rdata;
      d_resp_data = (err_q | store_q) ? 32'd0 : mem_rdata;

      // Outside val cycles the rdata outputs hold the last returned value.
      i_rdata_d = i_val_q ? i_resp_data : i_rdata_q;
      d_rdata_d = d_val_q ? d_resp_data : d_rdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last_q <= PORT_I;
         i_val_q   <= 1'b0;
         d_val_q   <= 1'b0;
         err_q     <= 1'b0;
         store_q   <= 1'b0;
         tag_q     <= '0;
         pc_q      <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         i_val_q   <= i_val_d;
         d_val_q   <= d_val_d;
         err_q     <= err_d;
         store_q   <= store_d;
         tag_q     <= tag_d;
         pc_q      <= pc_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign i__core_accept   = grant_i;
   assign d__core_accept   = grant_d;
   assign i__core_val      = i_val_q;
   assign d__core_val      = d_val_q;
   assign i__core_error    = i_val_q & err_q;
   assign d__core_error    = d_val_q & err_q;
   assign i__core_rdata    = i_rdata_d;
   assign d__core_rdata    = d_rdata_d;
   assign i__core_pc       = pc_q;
   assign d__core_resp_tag = tag_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arb
//
// Table-driven bench for mem_port_arb with a behavioural SRAM. Each table row
// is one cycle of requests together with the grant the arbiter must give.
// Expected responses are pushed to a scoreboard queue at grant time and
// compared one cycle later. Hand-written sequences cover post-reset conflict
// ordering and reset during an in-flight fetch.
// ---------------------------------------------------------------------------
module tb_mem_port_arb;

   localparam int DEPTH = 16384;
   localparam int AW    = 14;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] core__i_addr;
   logic        core__i_ren;
   logic        i__core_accept;
   logic        i__core_val;
   logic        i__core_error;
   logic [31:0] i__core_rdata;
   logic [31:0] i__core_pc;
   logic [31:0] core__d_addr;
   logic [31:0] core__d_wdata;
   logic        core__d_ren;
   logic [3:0]  core__d_wen;
   logic [10:0] core__d_req_tag;
   logic        d__core_accept;
   logic        d__core_val;
   logic        d__core_error;
   logic [31:0] d__core_rdata;
   logic [10:0] d__core_resp_tag;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_port_arb #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .core__i_addr     (core__i_addr),
      .core__i_ren      (core__i_ren),
      .i__core_accept   (i__core_accept),
      .i__core_val      (i__core_val),
      .i__core_error    (i__core_error),
      .i__core_rdata    (i__core_rdata),
      .i__core_pc       (i__core_pc),
      .core__d_addr     (core__d_addr),
      .core__d_wdata    (core__d_wdata),
      .core__d_ren      (core__d_ren),
      .core__d_wen      (core__d_wen),
      .core__d_req_tag  (core__d_req_tag),
      .d__core_accept   (d__core_accept),
      .d__core_val      (d__core_val),
      .d__core_error    (d__core_error),
      .d__core_rdata    (d__core_rdata),
      .d__core_resp_tag (d__core_resp_tag),
      .mem_en           (mem_en),
      .mem_wen          (mem_wen),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM with registered read.
   logic [31:0] sram [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wen != 4'd0) begin
            for (int b = 0; b < 4; b++)
               if (mem_wen[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr];
         end
      end
   end

   typedef struct {
      logic        i_ren;
      logic [31:0] i_addr;
      logic        d_ren;
      logic [3:0]  d_wen;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [10:0] tag;
      logic        exp_i;
      logic        exp_d;
   } vec_t;

   typedef struct {
      logic        is_i;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic [10:0] tag;
   } resp_t;

   logic [31:0] ref_mem [0:DEPTH-1];
   resp_t       sbq[$];
   vec_t        vecs[18];
   int          checks = 0;
   int          errors = 0;
   int          step_no = 0;
   logic [31:0] last_i_rdata, last_i_pc, last_d_rdata;
   logic [10:0] last_tag;

   function automatic vec_t mk(logic i_ren, logic [31:0] i_addr, logic d_ren,
                               logic [3:0] d_wen, logic [31:0] d_addr,
                               logic [31:0] d_wdata, logic [10:0] tag,
                               logic exp_i, logic exp_d);
      vec_t v;
      v.i_ren = i_ren;  v.i_addr = i_addr;  v.d_ren = d_ren;  v.d_wen = d_wen;
      v.d_addr = d_addr; v.d_wdata = d_wdata; v.tag = tag;
      v.exp_i = exp_i;  v.exp_d = exp_d;
      return v;
   endfunction

   function automatic logic out_of_range(logic [31:0] a);
`ifdef MEM_PORT_ARB_RANGE_CHECK_EN
      return a[31:AW+2] != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      core__i_ren     = v.i_ren;
      core__i_addr    = v.i_addr;
      core__d_ren     = v.d_ren;
      core__d_wen     = v.d_wen;
      core__d_addr    = v.d_addr;
      core__d_wdata   = v.d_wdata;
      core__d_req_tag = v.tag;
   endtask

   // Compare this cycle's response outputs against the scoreboard head.
   task automatic check_resp();
      resp_t r;
      if (sbq.size() > 0) begin
         r = sbq.pop_front();
         if (r.is_i) begin
            chk("i_val", i__core_val, 1);
            chk("d_val_idle", d__core_val, 0);
            chk("i_rdata", i__core_rdata, r.rdata);
            chk("i_pc", i__core_pc, r.pc);
            chk("i_error", i__core_error, r.err);
            last_i_rdata = r.rdata;
            last_i_pc    = r.pc;
         end else begin
            chk("d_val", d__core_val, 1);
            chk("i_val_idle", i__core_val, 0);
            chk("d_rdata", d__core_rdata, r.rdata);
            chk("d_tag", d__core_resp_tag, r.tag);
            chk("d_error", d__core_error, r.err);
            last_d_rdata = r.rdata;
            last_tag     = r.tag;
         end
      end else begin
         chk("i_val_none", i__core_val, 0);
         chk("d_val_none", d__core_val, 0);
         chk("i_error_none", i__core_error, 0);
         chk("d_error_none", d__core_error, 0);
         chk("i_rdata_hold", i__core_rdata, last_i_rdata);
         chk("i_pc_hold", i__core_pc, last_i_pc);
         chk("d_rdata_hold", d__core_rdata, last_d_rdata);
         chk("d_tag_hold", d__core_resp_tag, last_tag);
      end
   endtask

   // Check the grant and SRAM drive for row v, and queue the expected response.
   task automatic check_grant(vec_t v);
      resp_t       r;
      logic [31:0] a;
      logic [AW-1:0] w;
      logic        oor, store;
      chk("i_accept", i__core_accept, v.exp_i);
      chk("d_accept", d__core_accept, v.exp_d);
      chk("both_accept", i__core_accept & d__core_accept, 0);
      if (v.exp_i | v.exp_d) begin
         a     = v.exp_d ? v.d_addr : v.i_addr;
         w     = a[AW+1:2];
         oor   = out_of_range(a);
         store = v.exp_d && (v.d_wen != 4'd0);
         chk("mem_en", mem_en, !oor);
         chk("mem_addr", mem_addr, w);
         chk("mem_wen", mem_wen, (store && !oor) ? v.d_wen : 4'd0);
         if (store) chk("mem_wdata", mem_wdata, v.d_wdata);
         r.is_i  = v.exp_i;
         r.err   = oor;
         r.pc    = v.i_addr;
         r.tag   = v.tag;
         r.rdata = (oor || store) ? 32'd0 : ref_mem[w];
         if (store && !oor)
            for (int b = 0; b < 4; b++)
               if (v.d_wen[b]) ref_mem[w][8*b +: 8] = v.d_wdata[8*b +: 8];
         sbq.push_back(r);
      end else begin
         chk("mem_en_idle", mem_en, 0);
         chk("mem_wen_idle", mem_wen, 0);
      end
   endtask

   // One cycle: entered and left at posedge+1.
   task automatic step(vec_t v);
      drive(v);
      @(negedge clk);
      check_resp();
      $display("step %0d: i_acc=%b d_acc=%b mem_en=%b mem_addr=%h mem_wen=%b i_val=%b i_rdata=%h d_val=%b d_rdata=%h tag=%h",
               step_no, i__core_accept, d__core_accept, mem_en, mem_addr, mem_wen,
               i__core_val, i__core_rdata, d__core_val, d__core_rdata, d__core_resp_tag);
      check_grant(v);
      step_no++;
      @(posedge clk);
      #1;
   endtask

   // Reset for one cycle with both requests held: nothing may be granted.
   task automatic do_reset();
      rst = 1'b1;
      drive(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 0, 0, 0));
      sbq.delete();
      last_i_rdata = 0; last_i_pc = 0; last_d_rdata = 0; last_tag = 0;
      @(negedge clk);
      chk("rst_i_accept", i__core_accept, 0);
      chk("rst_d_accept", d__core_accept, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wen", mem_wen, 0);
      check_resp();
      $display("reset: i_val=%b d_val=%b mem_en=%b", i__core_val, d__core_val, mem_en);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         sram[k]    = 32'd0;
         ref_mem[k] = 32'd0;
      end
      sram[4]    = 32'h00500093;
      ref_mem[4] = 32'h00500093;
      mem_rdata  = 32'd0;

      //          i_ren i_addr        d_ren d_wen    d_addr        d_wdata        tag     exp_i exp_d
      vecs[0]  = mk(1, 32'h10,        0, 4'b0000, 32'h0,        32'h0,         11'h0,   1, 0);
      vecs[1]  = mk(0, 32'h0,         0, 4'b0011, 32'h100,      32'hDEADBEEF,  11'h7A5, 0, 1);
      vecs[2]  = mk(0, 32'h0,         1, 4'b0000, 32'h100,      32'h0,         11'h011, 0, 1);
      vecs[3]  = mk(0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,         11'h0,   0, 0);
      vecs[4]  = mk(0, 32'h0,         1, 4'b0000, 32'h10,       32'h0,         11'h001, 0, 1);
      vecs[5]  = mk(0, 32'h0,         1, 4'b0000, 32'h104,      32'h0,         11'h002, 0, 1);
      vecs[6]  = mk(0, 32'h0,         1, 4'b0000, 32'h0,        32'h0,         11'h003, 0, 1);
      vecs[7]  = mk(1, 32'h14,        1, 4'b0000, 32'h10,       32'h0,         11'h004, 1, 0);
      vecs[8]  = mk(1, 32'h14,        1, 4'b0000, 32'h10,       32'h0,         11'h004, 0, 1);
      vecs[9]  = mk(1, 32'h14,        1, 4'b0000, 32'h10,       32'h0,         11'h004, 1, 0);
      vecs[10] = mk(0, 32'h0,         0, 4'b1111, 32'h200,      32'h12345678,  11'h055, 0, 1);
      vecs[11] = mk(1, 32'h200,       0, 4'b0000, 32'h0,        32'h0,         11'h0,   1, 0);
      vecs[12] = mk(0, 32'h0,         1, 4'b0000, 32'h00010000, 32'h0,         11'h066, 0, 1);
      vecs[13] = mk(0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,         11'h0,   0, 0);
      vecs[14] = mk(0, 32'h0,         1, 4'b1000, 32'h200,      32'hAABBCCDD,  11'h077, 0, 1);
      vecs[15] = mk(0, 32'h0,         1, 4'b0000, 32'h203,      32'h0,         11'h078, 0, 1);
      vecs[16] = mk(1, 32'h40000010,  0, 4'b0000, 32'h0,        32'h0,         11'h0,   1, 0);
      vecs[17] = mk(0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,         11'h0,   0, 0);

      rst = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      do_reset();

      for (int k = 0; k < 18; k++) step(vecs[k]);

      // After reset, a held conflict is served D, I, D, I.
      do_reset();
      step(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 11'h101, 0, 1));
      step(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 11'h101, 1, 0));
      step(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 11'h102, 0, 1));
      step(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 11'h102, 1, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset right after a granted fetch drops its response and restores
      // the D-first conflict order.
      step(mk(1, 32'h10, 0, 4'b0000, 32'h0, 0, 11'h0, 1, 0));
      step(mk(1, 32'h10, 1, 4'b0000, 32'h104, 0, 11'h200, 0, 1));
      step(mk(1, 32'h10, 0, 4'b0000, 32'h0, 0, 11'h0, 1, 0));
      do_reset();
      step(mk(1, 32'h14, 1, 4'b0000, 32'h10, 0, 11'h3C3, 0, 1));
      step(mk(1, 32'h14, 0, 4'b0000, 32'h0, 0, 11'h0, 1, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
